display_timing_gen: RTL and testbench



---
 rtl/display_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_display_timing_gen.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
//
// Raster timing generator that sits at the head of the video path. It walks a
// horizontal counter (sx) and a vertical counter (sy) over the full raster,
// including blanking. From the coordinate it presents on each step, it decodes
// data-enable, horizontal/vertical sync and the line/frame strobes.
//
// All outputs are registered. The decode logic works on the *next*
// coordinate, so every flag lines up with the (sx,sy) that is presented on the
// same cycle. No input has a combinational path to any output.
//
// Ports
//   clk_pix   in   1      pixel clock; the only clock domain
//   sim_rst_n in   1      synchronous active-low reset
//   pix_ce    in   1      pixel clock enable; the raster advances only when high
//   sx        out  CORDW  horizontal position, 0..H_TOTAL-1
//   sy        out  CORDW  vertical position, 0..V_TOTAL-1
//   de        out  1      high while (sx,sy) is inside the active picture
//   hsync     out  1      horizontal sync, active level = SYNC_POL
//   vsync     out  1      vertical sync, active level = SYNC_POL
//   line      out  1      one-step strobe when sx==0
//   frame     out  1      one-step strobe when sx==0 and sy==0
// -----------------------------------------------------------------------------
module display_timing_gen #(
    parameter int   CORDW    = 10,
    parameter int   H_RES    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_RES    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk_pix,
    input  logic             sim_rst_n,
    input  logic             pix_ce,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line,
    output logic             frame
);

    // -------------------------------------------------------------------------
    // Derived raster geometry
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Every boundary is held as an unsigned CORDW-bit constant, so each
    // comparison below is a plain same-width unsigned compare.
    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACTIVE = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACTIVE = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC - 1);

    // A raster that cannot be addressed by the coordinate counters would wrap
    // silently, so refuse to build it.
    if (H_TOTAL > (1 << CORDW)) begin : g_h_total_too_wide
        $fatal(1, "display_timing_gen: H_TOTAL (%0d) exceeds 2**CORDW", H_TOTAL);
    end
    if (V_TOTAL > (1 << CORDW)) begin : g_v_total_too_wide
        $fatal(1, "display_timing_gen: V_TOTAL (%0d) exceeds 2**CORDW", V_TOTAL);
    end
    if (H_RES < 1 || V_RES < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_geometry
        $fatal(1, "display_timing_gen: active area and sync widths must be non-zero");
    end

    // -------------------------------------------------------------------------
    // Next coordinate and its decoded flags
    // -------------------------------------------------------------------------
    logic [CORDW-1:0] sx_next;
    logic [CORDW-1:0] sy_next;
    logic             de_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             line_next;
    logic             frame_next;

    // NOTE: every signal driven from always_comb receives a default at the top
    // of the block, so no path through the branches can leave it unassigned
    // and infer a latch.
    always_comb begin
        sx_next = sx + 1'b1;
        sy_next = sy;

        if (sx == H_LAST) begin
            sx_next = '0;
            if (sy == V_LAST) begin
                sy_next = '0;
            end else begin
                sy_next = sy + 1'b1;
            end
        end
    end

    always_comb begin
        de_next    = (sx_next < H_ACTIVE) && (sy_next < V_ACTIVE);
        hsync_next = ~SYNC_POL;
        vsync_next = ~SYNC_POL;

        if ((sx_next >= HS_START) && (sx_next <= HS_END)) begin
            hsync_next = SYNC_POL;
        end

        // vsync covers whole lines, so it depends on sy only.
        if ((sy_next >= VS_START) && (sy_next <= VS_END)) begin
            vsync_next = SYNC_POL;
        end

        line_next  = (sx_next == '0);
        frame_next = (sx_next == '0) && (sy_next == '0);
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    // Reset parks the raster on its final position, so the first enabled step
    // after release lands on (0,0) with both strobes raised. Reset wins over
    // pix_ce and takes effect on the edge it is seen, even mid-line.
    //
    // With pix_ce low the coordinate and its level-type flags hold, while the
    // strobes drop, so each strobe marks exactly one enabled step.
    //
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, whatever order the statements
    // appear in.
    always_ff @(posedge clk_pix) begin
        if (!sim_rst_n) begin
            sx    <= H_LAST;
            sy    <= V_LAST;
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            line  <= 1'b0;
            frame <= 1'b0;
        end else if (pix_ce) begin
            sx    <= sx_next;
            sy    <= sy_next;
            de    <= de_next;
            hsync <= hsync_next;
            vsync <= vsync_next;
            line  <= line_next;
            frame <= frame_next;
        end else begin
            line  <= 1'b0;
            frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_display_timing_gen
//
// Directed self-checking bench for display_timing_gen. Three instances share
// the pixel clock:
//   dut   - default 640x480 geometry (horizontal timing, enable, reset)
//   dut_m - default horizontal timing, 15-line raster (vsync, frame wrap)
//   dut_s - 7x5 raster, active-high syncs, 3-bit coordinates
// Each instance has its own reset and enable, so the others stay parked in
// reset while one is exercised.
// -----------------------------------------------------------------------------
module tb_display_timing_gen;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    int tests = 0;
    int fails = 0;

    // ---------------- default instance ----------------
    logic       rst_n, ce;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync, line, frame;

    display_timing_gen dut (
        .clk_pix(clk_pix), .sim_rst_n(rst_n), .pix_ce(ce),
        .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
        .line(line), .frame(frame)
    );

    // ---------------- 800x15 instance ----------------
    logic       rst_m, ce_m;
    logic [9:0] sx_m, sy_m;
    logic       de_m, hs_m, vs_m, line_m, frame_m;

    display_timing_gen #(
        .CORDW(10), .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_m (
        .clk_pix(clk_pix), .sim_rst_n(rst_m), .pix_ce(ce_m),
        .sx(sx_m), .sy(sy_m), .de(de_m), .hsync(hs_m), .vsync(vs_m),
        .line(line_m), .frame(frame_m)
    );

    // ---------------- 7x5 instance ----------------
    logic       rst_s, ce_s;
    logic [2:0] sx_s, sy_s;
    logic       de_s, hs_s, vs_s, line_s, frame_s;

    display_timing_gen #(
        .CORDW(3), .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_s (
        .clk_pix(clk_pix), .sim_rst_n(rst_s), .pix_ce(ce_s),
        .sx(sx_s), .sy(sy_s), .de(de_s), .hsync(hs_s), .vsync(vs_s),
        .line(line_s), .frame(frame_s)
    );

    // Advance one clock and land 1 ns after the edge, where outputs are
    // sampled and the next inputs are applied.
    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Step the default instance with pix_ce high until sx reaches target.
    task automatic run_to_sx(input int target, output bit ok);
        ok = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (sx == 10'(target)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        // Reset with pix_ce low: reset must still take effect.
        rst_n = 1'b0;
        ce    = 1'b0;
        tick();
        tests++;
        if (sx !== 10'd799 || sy !== 10'd524) begin
            fails++;
            $display("FAIL reset_coord: got (%0d,%0d) expected (799,524)", sx, sy);
        end
        tests++;
        if ({de, hsync, vsync, line, frame} !== 5'b01100) begin
            fails++;
            $display("FAIL reset_flags: de/hs/vs/line/frame got %b expected 01100",
                     {de, hsync, vsync, line, frame});
        end
    endtask

    task automatic test_first_step();
        rst_n = 1'b1;
        ce    = 1'b1;
        tick();
        tests++;
        if (sx !== 10'd0 || sy !== 10'd0) begin
            fails++;
            $display("FAIL first_coord: got (%0d,%0d) expected (0,0)", sx, sy);
        end
        tests++;
        if ({de, hsync, vsync, line, frame} !== 5'b11111) begin
            fails++;
            $display("FAIL first_flags: de/hs/vs/line/frame got %b expected 11111",
                     {de, hsync, vsync, line, frame});
        end
        tick();
        tests++;
        if (sx !== 10'd1 || {line, frame} !== 2'b00) begin
            fails++;
            $display("FAIL second_step: sx=%0d line/frame=%b expected sx=1 line/frame=00",
                     sx, {line, frame});
        end
    endtask

    // Starts at (1,0); 800 steps cover the rest of line 0 and sx=0..1 of line 1.
    task automatic test_one_line();
        int pos = 1;
        int coord_err = 0, flag_err = 0, de_cnt = 0, hs_cnt = 0;
        bit wrapped = 1'b0;
        int ex, ey;
        ce = 1'b1;
        for (int i = 0; i < 800; i++) begin
            tick();
            pos++;
            ex = pos % 800;
            ey = pos / 800;
            if (sx !== 10'(ex) || sy !== 10'(ey)) coord_err++;
            if (de === 1'b1) de_cnt++;
            if (hsync === 1'b0) hs_cnt++;
            if (hsync !== ((ex >= 656 && ex <= 751) ? 1'b0 : 1'b1)) flag_err++;
            if (line !== (ex == 0) || frame !== 1'b0 || vsync !== 1'b1) flag_err++;
            if (ex == 0 && ey == 1 && sx === 10'd0 && sy === 10'd1 && line === 1'b1)
                wrapped = 1'b1;
        end
        tests++;
        if (coord_err !== 0) begin
            fails++;
            $display("FAIL line_coords: %0d cycles off the expected raster position", coord_err);
        end
        tests++;
        if (de_cnt !== 640) begin
            fails++;
            $display("FAIL line_de_count: got %0d expected 640", de_cnt);
        end
        tests++;
        if (hs_cnt !== 96) begin
            fails++;
            $display("FAIL line_hsync_count: got %0d expected 96", hs_cnt);
        end
        tests++;
        if (flag_err !== 0) begin
            fails++;
            $display("FAIL line_flags: %0d cycles with wrong hsync/vsync/line/frame", flag_err);
        end
        tests++;
        if (wrapped !== 1'b1) begin
            fails++;
            $display("FAIL line_wrap: got %0b expected 1 for sx=799 -> (0,1) with line", wrapped);
        end
    endtask

    task automatic test_ce_hold();
        bit ok;
        run_to_sx(100, ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL hold_reach100: timeout, sx=%0d expected 100", sx);
        end
        tick();
        tests++;
        if (sx !== 10'd101) begin
            fails++;
            $display("FAIL hold_pre: sx=%0d expected 101", sx);
        end
        ce = 1'b0;
        tick();
        tick();
        tests++;
        if (sx !== 10'd101 || de !== 1'b1 || sy !== 10'd1) begin
            fails++;
            $display("FAIL hold_disabled: sx=%0d sy=%0d de=%b expected 101 1 1", sx, sy, de);
        end
        ce = 1'b1;
        tick();
        tests++;
        if (sx !== 10'd102) begin
            fails++;
            $display("FAIL hold_resume: sx=%0d expected 102", sx);
        end

        // hsync holds its active level while disabled.
        run_to_sx(700, ok);
        ce = 1'b0;
        tick();
        tests++;
        if (ok !== 1'b1 || sx !== 10'd700 || hsync !== 1'b0) begin
            fails++;
            $display("FAIL hold_hsync: sx=%0d hsync=%b expected 700 0", sx, hsync);
        end

        // A strobe is not repeated while disabled.
        run_to_sx(799, ok);
        tick();
        tests++;
        if (ok !== 1'b1 || sx !== 10'd0 || sy !== 10'd2 || line !== 1'b1) begin
            fails++;
            $display("FAIL strobe_raise: (%0d,%0d) line=%b expected (0,2) line=1", sx, sy, line);
        end
        ce = 1'b0;
        tick();
        tests++;
        if (sx !== 10'd0 || line !== 1'b0 || de !== 1'b1) begin
            fails++;
            $display("FAIL strobe_drop: sx=%0d line=%b de=%b expected 0 0 1", sx, line, de);
        end
        tick();
        ce = 1'b1;
        tick();
        tests++;
        if (sx !== 10'd1 || line !== 1'b0) begin
            fails++;
            $display("FAIL strobe_no_repeat: sx=%0d line=%b expected 1 0", sx, line);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        run_to_sx(300, ok);
        tests++;
        if (ok !== 1'b1 || sy !== 10'd2 || de !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: (%0d,%0d) de=%b expected (300,2) de=1", sx, sy, de);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if (sx !== 10'd799 || sy !== 10'd524 ||
            {de, hsync, vsync, line, frame} !== 5'b01100) begin
            fails++;
            $display("FAIL midrst_state: (%0d,%0d) flags=%b expected (799,524) 01100",
                     sx, sy, {de, hsync, vsync, line, frame});
        end
        tick();
        tests++;
        if (sx !== 10'd0 || sy !== 10'd0 || frame !== 1'b1 || line !== 1'b1) begin
            fails++;
            $display("FAIL midrst_restart: (%0d,%0d) frame=%b expected (0,0) frame=1",
                     sx, sy, frame);
        end
    endtask

    // One full 800x15 frame: vsync only on lines 10..11, a single frame strobe.
    task automatic test_frame();
        int pos = 0;
        int coord_err = 0, flag_err = 0, vs_cnt = 0, frames = 0, lines = 0;
        int ex, ey;
        bit wrapped = 1'b0;
        rst_m = 1'b0;
        ce_m  = 1'b1;
        tick();
        tests++;
        if (sx_m !== 10'd799 || sy_m !== 10'd14 || vs_m !== 1'b1) begin
            fails++;
            $display("FAIL frame_reset: (%0d,%0d) vs=%b expected (799,14) 1", sx_m, sy_m, vs_m);
        end
        rst_m = 1'b0;
        rst_m = 1'b1;
        tick();
        tests++;
        if (sx_m !== 10'd0 || sy_m !== 10'd0 || frame_m !== 1'b1) begin
            fails++;
            $display("FAIL frame_first: (%0d,%0d) frame=%b expected (0,0) 1", sx_m, sy_m, frame_m);
        end
        for (int i = 0; i < 12000; i++) begin
            tick();
            pos = (pos + 1) % 12000;
            ex = pos % 800;
            ey = pos / 800;
            if (sx_m !== 10'(ex) || sy_m !== 10'(ey)) coord_err++;
            if (vs_m === 1'b0) vs_cnt++;
            if (frame_m === 1'b1) frames++;
            if (line_m === 1'b1) lines++;
            if (vs_m !== ((ey >= 10 && ey <= 11) ? 1'b0 : 1'b1)) flag_err++;
            if (frame_m !== (pos == 0)) flag_err++;
            if (de_m !== (ex < 640 && ey < 8)) flag_err++;
            if (pos == 0 && sx_m === 10'd0 && sy_m === 10'd0) wrapped = 1'b1;
        end
        tests++;
        if (coord_err !== 0) begin
            fails++;
            $display("FAIL frame_coords: %0d cycles off the expected raster position", coord_err);
        end
        tests++;
        if (flag_err !== 0) begin
            fails++;
            $display("FAIL frame_flags: %0d cycles with wrong vsync/frame/de", flag_err);
        end
        tests++;
        if (vs_cnt !== 1600) begin
            fails++;
            $display("FAIL frame_vsync_count: got %0d expected 1600", vs_cnt);
        end
        tests++;
        if (frames !== 1 || lines !== 15) begin
            fails++;
            $display("FAIL frame_strobes: frames=%0d lines=%0d expected 1 15", frames, lines);
        end
        tests++;
        if (wrapped !== 1'b1) begin
            fails++;
            $display("FAIL frame_wrap: got %0b expected 1 for (799,14) -> (0,0)", wrapped);
        end
        rst_m = 1'b0;
    endtask

    // 7x5 raster with active-high syncs over two frame periods.
    task automatic test_small();
        int pos = 34;
        int err = 0, frames = 0, first = -1, second = -1;
        int ex, ey;
        rst_s = 1'b0;
        ce_s  = 1'b1;
        tick();
        tests++;
        if (sx_s !== 3'd6 || sy_s !== 3'd4 ||
            {de_s, hs_s, vs_s, line_s, frame_s} !== 5'b00000) begin
            fails++;
            $display("FAIL small_reset: (%0d,%0d) flags=%b expected (6,4) 00000",
                     sx_s, sy_s, {de_s, hs_s, vs_s, line_s, frame_s});
        end
        rst_s = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            pos = (pos + 1) % 35;
            ex = pos % 7;
            ey = pos / 7;
            if (sx_s !== 3'(ex) || sy_s !== 3'(ey)) err++;
            if (hs_s !== (ex == 5) || vs_s !== (ey == 3)) err++;
            if (de_s !== (ex < 4 && ey < 2)) err++;
            if (line_s !== (ex == 0) || frame_s !== (pos == 0)) err++;
            if (frame_s === 1'b1) begin
                frames++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        tests++;
        if (err !== 0) begin
            fails++;
            $display("FAIL small_raster: %0d mismatching checks over 70 cycles", err);
        end
        tests++;
        if (frames !== 2 || second - first !== 35) begin
            fails++;
            $display("FAIL small_frame_period: frames=%0d period=%0d expected 2 35",
                     frames, second - first);
        end
        rst_s = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ce   = 1'b0;
        rst_m = 1'b0; ce_m = 1'b0;
        rst_s = 1'b0; ce_s = 1'b0;
        tick();
        test_reset();
        test_first_step();
        test_one_line();
        test_ce_hold();
        test_mid_reset();
        test_frame();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
